// File: rtl/i2c_poll_sequencer_if.sv
// Handshake bundle between the poll sequencer and the low-level I2C master.
// The sequencer side drives the request fields; the master returns busy/done/nack and read data.
interface i2c_poll_sequencer_if #(
  parameter int MAX_BYTES = 6
);
  localparam int NB_W = $clog2(MAX_BYTES + 1);

  logic                   ll_start;
  logic                   ll_write;
  logic [6:0]             ll_dev_addr;
  logic [7:0]             ll_reg_addr;
  logic [NB_W-1:0]        ll_num_bytes;
  logic [7:0]             ll_wdata;
  logic                   ll_busy;
  logic                   ll_done;
  logic                   ll_nack;
  logic [8*MAX_BYTES-1:0] ll_rdata;

  modport master (
    output ll_start, ll_write, ll_dev_addr, ll_reg_addr, ll_num_bytes, ll_wdata,
    input  ll_busy, ll_done, ll_nack, ll_rdata
  );

  modport slave (
    input  ll_start, ll_write, ll_dev_addr, ll_reg_addr, ll_num_bytes, ll_wdata,
    output ll_busy, ll_done, ll_nack, ll_rdata
  );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// Poll sequencer for one I2C peripheral: two-write init, then per tick a pointer write,
// a conversion delay and an N-byte read. Failed transactions (NACK or timeout) abort to IDLE;
// MAX_FAILS consecutive failed polls force a re-init on the next tick.
// Optional build macro NUNCHUCK_DECODE_EN adds decoded nunchuck fields (needs MAX_BYTES >= 6).
//
// state | meaning
// IDLE  | waiting for a poll tick with enable=1
// INIT0 | write INIT_DATA0 to INIT_REG0
// INIT1 | write INIT_DATA1 to INIT_REG1, sets init_done on success
// PTR   | pointer-only write of READ_REG
// DLY   | conversion delay of READ_DELAY cycles
// RD    | read MAX_BYTES from READ_REG, publishes the sample on success
module i2c_poll_sequencer #(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         POLL_HZ    = 100,
  parameter int         MAX_BYTES  = 6,
  parameter logic [6:0] DEV_ADDR   = 7'h52,
  parameter logic [7:0] INIT_REG0  = 8'hF0,
  parameter logic [7:0] INIT_DATA0 = 8'h55,
  parameter logic [7:0] INIT_REG1  = 8'hFB,
  parameter logic [7:0] INIT_DATA1 = 8'h00,
  parameter logic [7:0] READ_REG   = 8'h00,
  parameter int         READ_DELAY = 10_000,
  parameter int         TIMEOUT    = 200_000,
  parameter int         MAX_FAILS  = 3
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   enable,
  i2c_poll_sequencer_if.master   ll,
  output logic [8*MAX_BYTES-1:0] sample_data,
  output logic                   sample_valid,
  output logic                   init_done,
  output logic [7:0]             fail_cnt,
  output logic                   overrun
`ifdef NUNCHUCK_DECODE_EN
  ,
  output logic [7:0]             stick_x,
  output logic [7:0]             stick_y,
  output logic [9:0]             accel_x,
  output logic [9:0]             accel_y,
  output logic [9:0]             accel_z,
  output logic                   z,
  output logic                   c
`endif
);

  localparam int POLL_DIV = CLK_HZ / POLL_HZ;
  localparam int TICK_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int NB_W     = $clog2(MAX_BYTES + 1);
  localparam int TMR_MAX  = (TIMEOUT > READ_DELAY) ? TIMEOUT : READ_DELAY;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int FC_W     = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

  typedef enum logic [2:0] {IDLE, INIT0, INIT1, PTR, DLY, RD} state_t;

  state_t            state;
  logic              waiting;   // transaction issued, waiting for ll_done or timeout
  logic [TMR_W-1:0]  tmr;       // shared down-counter: timeout in wait phase, delay in DLY
  logic [FC_W-1:0]   consec;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              txn_fail;
  logic              txn_good;

  assign tick = (tick_cnt == TICK_W'(POLL_DIV - 1));

  // waiting is only ever set in INIT0/INIT1/PTR/RD, so it qualifies both outcomes
  assign txn_good = waiting && ll.ll_done && !ll.ll_nack;
  assign txn_fail = waiting && ((ll.ll_done && ll.ll_nack) || (!ll.ll_done && tmr == '0));

  // Free-running poll tick divider, independent of enable
  always_ff @(posedge clock) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Sequencer FSM with registered handshake and sample outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state           <= IDLE;
      waiting         <= 1'b0;
      tmr             <= '0;
      consec          <= '0;
      ll.ll_start     <= 1'b0;
      ll.ll_write     <= 1'b0;
      ll.ll_dev_addr  <= '0;
      ll.ll_reg_addr  <= '0;
      ll.ll_num_bytes <= '0;
      ll.ll_wdata     <= '0;
      sample_data     <= '0;
      sample_valid    <= 1'b0;
      init_done       <= 1'b0;
      fail_cnt        <= '0;
      overrun         <= 1'b0;
`ifdef NUNCHUCK_DECODE_EN
      stick_x <= '0;
      stick_y <= '0;
      accel_x <= '0;
      accel_y <= '0;
      accel_z <= '0;
      z       <= 1'b0;
      c       <= 1'b0;
`endif
    end else begin
      ll.ll_start  <= 1'b0;
      sample_valid <= 1'b0;
      // ticks outside IDLE are dropped, never queued
      if (tick && state != IDLE) overrun <= 1'b1;

      if (txn_fail) begin
        state   <= IDLE;
        waiting <= 1'b0;
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 1'b1;
        if (state == PTR || state == RD) begin
          if (consec == FC_W'(MAX_FAILS - 1)) begin
            consec    <= '0;
            init_done <= 1'b0;
          end else begin
            consec <= consec + 1'b1;
          end
        end
      end else if (txn_good) begin
        waiting <= 1'b0;
        case (state)
          INIT0: state <= INIT1;
          INIT1: begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
          PTR: begin
            tmr   <= TMR_W'(READ_DELAY - 1);
            state <= DLY;
          end
          default: begin
            sample_data  <= ll.ll_rdata;
            sample_valid <= 1'b1;
            consec       <= '0;
            state        <= IDLE;
`ifdef NUNCHUCK_DECODE_EN
            stick_x <= ll.ll_rdata[7:0];
            stick_y <= ll.ll_rdata[15:8];
            accel_x <= {ll.ll_rdata[23:16], ll.ll_rdata[43:42]};
            accel_y <= {ll.ll_rdata[31:24], ll.ll_rdata[45:44]};
            accel_z <= {ll.ll_rdata[39:32], ll.ll_rdata[47:46]};
            z       <= ~ll.ll_rdata[40];
            c       <= ~ll.ll_rdata[41];
`endif
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            // a late ll_done from a timed-out transaction lands here and is ignored
            if (tick && enable) begin
              waiting <= 1'b0;
              state   <= init_done ? PTR : INIT0;
            end
          end
          DLY: begin
            if (tmr == '0) begin
              waiting <= 1'b0;
              state   <= RD;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          default: begin
            if (!waiting) begin
              if (!ll.ll_busy) begin
                // request fields change only here, so they stay stable until ll_done
                ll.ll_start    <= 1'b1;
                ll.ll_dev_addr <= DEV_ADDR;
                waiting        <= 1'b1;
                tmr            <= TMR_W'(TIMEOUT - 1);
                case (state)
                  INIT0: begin
                    ll.ll_write     <= 1'b1;
                    ll.ll_reg_addr  <= INIT_REG0;
                    ll.ll_num_bytes <= NB_W'(1);
                    ll.ll_wdata     <= INIT_DATA0;
                  end
                  INIT1: begin
                    ll.ll_write     <= 1'b1;
                    ll.ll_reg_addr  <= INIT_REG1;
                    ll.ll_num_bytes <= NB_W'(1);
                    ll.ll_wdata     <= INIT_DATA1;
                  end
                  PTR: begin
                    ll.ll_write     <= 1'b1;
                    ll.ll_reg_addr  <= READ_REG;
                    ll.ll_num_bytes <= '0;
                    ll.ll_wdata     <= 8'h00;
                  end
                  default: begin
                    ll.ll_write     <= 1'b0;
                    ll.ll_reg_addr  <= READ_REG;
                    ll.ll_num_bytes <= NB_W'(MAX_BYTES);
                    ll.ll_wdata     <= 8'h00;
                  end
                endcase
              end
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Directed bench for i2c_poll_sequencer with a small behavioural low-level master.
// Short POLL_DIV/READ_DELAY/TIMEOUT keep the run to roughly a thousand cycles.
module tb_i2c_poll_sequencer;

  localparam int CLK_HZ     = 1000;
  localparam int POLL_HZ    = 10;     // POLL_DIV = 100
  localparam int MAX_BYTES  = 6;
  localparam int READ_DELAY = 10;
  localparam int TIMEOUT    = 40;
  localparam int MAX_FAILS  = 3;
  localparam int LAT        = 3;      // master answers LAT cycles after ll_start

  typedef struct {
    int         cyc;
    logic       wr;
    logic [7:0] ra;
    logic [2:0] nb;
    logic [7:0] wd;
  } start_t;

  logic                   clock;
  logic                   rst;
  logic                   enable;
  logic [8*MAX_BYTES-1:0] sample_data;
  logic                   sample_valid;
  logic                   init_done;
  logic [7:0]             fail_cnt;
  logic                   overrun;
`ifdef NUNCHUCK_DECODE_EN
  logic [7:0] stick_x, stick_y;
  logic [9:0] accel_x, accel_y, accel_z;
  logic       z, c;
`endif

  i2c_poll_sequencer_if #(.MAX_BYTES(MAX_BYTES)) ll();

  i2c_poll_sequencer #(
    .CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ), .MAX_BYTES(MAX_BYTES),
    .READ_DELAY(READ_DELAY), .TIMEOUT(TIMEOUT), .MAX_FAILS(MAX_FAILS)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .ll(ll),
    .sample_data(sample_data), .sample_valid(sample_valid), .init_done(init_done),
    .fail_cnt(fail_cnt), .overrun(overrun)
`ifdef NUNCHUCK_DECODE_EN
    , .stick_x(stick_x), .stick_y(stick_y), .accel_x(accel_x), .accel_y(accel_y),
    .accel_z(accel_z), .z(z), .c(c)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // master model controls and observations
  logic                   silent = 1'b0;
  logic                   nack_rd = 1'b0;
  logic                   busy_force = 1'b0;
  logic [8*MAX_BYTES-1:0] rdata_val = 48'h1122_3344_5566;
  int                     inj_req = 0;
  int                     inj_seen = 0;
  int                     sv_count = 0;
  int                     sv_cyc = 0;
  start_t                 st_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (st_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (st_q.size() < n) check_val(tag, 64'(st_q.size()), 64'(n));
  endtask

  // Low-level master model: acts on the falling edge, away from the DUT's sampling edge
  initial begin : master_model
    int  cd;
    logic pend_nack;
    cd = 0;
    pend_nack = 1'b0;
    ll.ll_busy = 1'b0;
    ll.ll_done = 1'b0;
    ll.ll_nack = 1'b0;
    ll.ll_rdata = '0;
    forever begin
      @(negedge clock);
      ll.ll_done = 1'b0;
      ll.ll_nack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ll.ll_done  = 1'b1;
          ll.ll_nack  = pend_nack;
          ll.ll_rdata = rdata_val;
        end
      end
      if (inj_req != inj_seen) begin
        inj_seen    = inj_req;
        ll.ll_done  = 1'b1;
        ll.ll_rdata = rdata_val;
      end
      if (ll.ll_start) begin
        st_q.push_back('{cyc, ll.ll_write, ll.ll_reg_addr, ll.ll_num_bytes, ll.ll_wdata});
        if (!silent) begin
          cd = LAT;
          pend_nack = nack_rd && !ll.ll_write;
        end
      end
      if (sample_valid) begin
        sv_count++;
        sv_cyc = cyc;
      end
      ll.ll_busy = busy_force || (cd > 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k, s, f, r, n0;
    rst = 1'b1;
    enable = 1'b0;
    step(3);
    check_val("rst_start",   64'(ll.ll_start), 64'd0);
    check_val("rst_init",    64'(init_done),   64'd0);
    check_val("rst_failcnt", 64'(fail_cnt),    64'd0);
    check_val("rst_sample",  64'(sample_data), 64'd0);
    check_val("rst_valid",   64'(sample_valid), 64'd0);
    check_val("rst_overrun", 64'(overrun),     64'd0);

    // 1: init writes, then pointer write and read
    rst = 1'b0;
    enable = 1'b1;
    wait_starts(2, 300, "init_starts");
    k = 0;
    while (!init_done && k < 30) begin step(1); k++; end
    check_val("init_done",  64'(init_done), 64'd1);
    check_val("init0_wr",   64'(st_q[0].wr), 64'd1);
    check_val("init0_reg",  64'(st_q[0].ra), 64'hF0);
    check_val("init0_data", 64'(st_q[0].wd), 64'h55);
    check_val("init0_nb",   64'(st_q[0].nb), 64'd1);
    check_val("init1_reg",  64'(st_q[1].ra), 64'hFB);
    check_val("init1_data", 64'(st_q[1].wd), 64'h00);
    wait_starts(4, 250, "poll_starts");
    check_val("ptr_wr",  64'(st_q[2].wr), 64'd1);
    check_val("ptr_reg", 64'(st_q[2].ra), 64'h00);
    check_val("ptr_nb",  64'(st_q[2].nb), 64'd0);
    check_val("rd_wr",   64'(st_q[3].wr), 64'd0);
    check_val("rd_nb",   64'(st_q[3].nb), 64'd6);
    // done arrives LAT after PTR start; one cycle to enter DLY, READ_DELAY cycles of delay,
    // one issue cycle before ll_start shows
    check_val("rd_gap", 64'(st_q[3].cyc - st_q[2].cyc), 64'(LAT + READ_DELAY + 2));

    // 2: sample capture
    k = 0;
    while (sv_count < 1 && k < 50) begin step(1); k++; end
    check_val("sample_data", 64'(sample_data), 64'h1122_3344_5566);
    check_val("sample_lat",  64'(sv_cyc - st_q[3].cyc), 64'(LAT + 1));
    check_val("fail_zero",   64'(fail_cnt), 64'd0);
`ifdef NUNCHUCK_DECODE_EN
    check_val("stick_x", 64'(stick_x), 64'h66);
    check_val("stick_y", 64'(stick_y), 64'h55);
    check_val("accel_x", 64'(accel_x), 64'({8'h44, 2'b00}));
    check_val("accel_z", 64'(accel_z), 64'({8'h22, 2'b00}));
    check_val("z_btn",   64'(z), 64'd0);
    check_val("c_btn",   64'(c), 64'd1);
`endif
    step(5);
    check_val("sample_once", 64'(sv_count), 64'd1);

    // 3: three NACKed reads force re-init
    nack_rd = 1'b1;
    k = 0;
    while (fail_cnt != 8'd3 && k < 400) begin step(1); k++; end
    check_val("nack_failcnt", 64'(fail_cnt), 64'd3);
    check_val("nack_initlow", 64'(init_done), 64'd0);
    check_val("nack_nosample", 64'(sv_count), 64'd1);
    check_val("nack_hold", 64'(sample_data), 64'h1122_3344_5566);
    nack_rd = 1'b0;
    n0 = st_q.size();
    wait_starts(n0 + 1, 150, "reinit_start");
    check_val("reinit_reg",  64'(st_q[n0].ra), 64'hF0);
    check_val("reinit_data", 64'(st_q[n0].wd), 64'h55);

    // 4: no ll_done -> timeout
    k = 0;
    while (!init_done && k < 50) begin step(1); k++; end
    silent = 1'b1;
    n0 = st_q.size();
    wait_starts(n0 + 1, 150, "to_start");
    s = st_q[n0].cyc;
    check_val("to_is_ptr", 64'(st_q[n0].nb), 64'd0);
    k = 0;
    while (fail_cnt != 8'd4 && k < 100) begin step(1); k++; end
    f = cyc;
    check_val("to_failcnt", 64'(fail_cnt), 64'd4);
    check_val("to_exact",   64'(f - s), 64'(TIMEOUT));
    step(3);
    inj_req++;
    step(5);
    check_val("late_done_nosample", 64'(sv_count), 64'd1);
    check_val("late_done_idle",     64'(st_q.size()), 64'(n0 + 1));
    check_val("late_done_failcnt",  64'(fail_cnt), 64'd4);
    silent = 1'b0;

    // 5: busy across ticks withholds ll_start, extra tick sets overrun
    check_val("pre_overrun", 64'(overrun), 64'd0);
    busy_force = 1'b1;
    n0 = st_q.size();
    step(250);
    check_val("busy_nostart", 64'(st_q.size()), 64'(n0));
    check_val("overrun",      64'(overrun), 64'd1);
    busy_force = 1'b0;
    r = cyc;
    wait_starts(n0 + 1, 20, "busy_release");
    check_val("busy_gap", 64'(st_q[n0].cyc - r), 64'd1);
    check_val("busy_ptr", 64'(st_q[n0].ra), 64'h00);

    // 6: reset during DLY, stale done afterwards
    step(5);
    rst = 1'b1;
    step(1);
    check_val("rst6_start",   64'(ll.ll_start), 64'd0);
    check_val("rst6_init",    64'(init_done),   64'd0);
    check_val("rst6_failcnt", 64'(fail_cnt),    64'd0);
    check_val("rst6_overrun", 64'(overrun),     64'd0);
    check_val("rst6_sample",  64'(sample_data), 64'd0);
    rst = 1'b0;
    inj_req++;
    step(6);
    check_val("stale_nosample", 64'(sv_count), 64'd1);
    check_val("stale_data",     64'(sample_data), 64'd0);
    n0 = st_q.size();
    wait_starts(n0 + 1, 150, "post_rst_start");
    check_val("post_rst_reg", 64'(st_q[n0].ra), 64'hF0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
